// File: rtl/bcd_counter_n_pkg.sv
// bcd_counter_n_pkg: shared digit width, default modulus and the load clamp helper.
package bcd_counter_n_pkg;
   localparam int DIGIT_W = 4;
   localparam int MOD_BCD = 10;
   typedef logic [DIGIT_W-1:0] digit_t;
   // A loaded digit outside 0..m-1 is forced to 0 so counting never sees an illegal value.
   function automatic digit_t clamp_digit(input digit_t d, input int m);
      return (int'(d) >= m) ? '0 : d;
   endfunction
endpackage

// File: rtl/bcd_counter_n_if.sv
// bcd_counter_n_if: control, load and status bundle of one multi-digit counter.
interface bcd_counter_n_if #(parameter int DIGITS = 3);
   import bcd_counter_n_pkg::*;
   logic                       en;
   logic                       up;
   logic                       load;
   logic [DIGIT_W*DIGITS-1:0]  load_val;
   logic [DIGIT_W*DIGITS-1:0]  q;
   logic                       tc;
   logic                       wrap;
   modport master (output en, up, load, load_val, input q, tc, wrap);
   modport slave  (input en, up, load, load_val, output q, tc, wrap);
endinterface

// File: rtl/bcd_counter_n_digit.sv
// mod_digit: one modulo-MOD digit register with load clamp and wrap-around inc/dec.
module mod_digit
   import bcd_counter_n_pkg::*;
#(
   parameter int MOD = MOD_BCD
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   load,
   input  digit_t d,
   input  logic   inc,
   input  logic   dec,
   output digit_t q,
   output logic   at_max,
   output logic   at_zero
);
   localparam digit_t MAX_V = digit_t'(MOD - 1);
   digit_t r_q;
   always_ff @(posedge clk) begin
      if (!rst_n)    r_q <= '0;
      else if (load) r_q <= clamp_digit(d, MOD);
      else if (inc)  r_q <= at_max ? '0 : r_q + 4'd1;
      else if (dec)  r_q <= at_zero ? MAX_V : r_q - 4'd1;
   end
   assign q       = r_q;
   assign at_max  = (r_q == MAX_V);
   assign at_zero = (r_q == '0);
endmodule

// File: rtl/bcd_counter_n.sv
// bcd_counter_n: synchronous multi-digit modulo-MOD up/down counter with load,
// terminal count and a registered wrap pulse; digits cascade through a carry/borrow chain.
module bcd_counter_n
   import bcd_counter_n_pkg::*;
#(
   parameter int DIGITS = 3,
   parameter int MOD    = MOD_BCD
) (
   input logic            clk,
   input logic            rst_n,
   bcd_counter_n_if.slave bus
);
   logic [DIGITS-1:0]         w_at_max;
   logic [DIGITS-1:0]         w_at_zero;
   logic [DIGITS-1:0]         w_inc;
   logic [DIGITS-1:0]         w_dec;
   logic [DIGIT_W*DIGITS-1:0] w_q;
   logic                      w_tc;
   logic                      r_wrap;
   for (genvar i = 0; i < DIGITS; i++) begin : g_dig
      mod_digit #(.MOD(MOD)) u_digit (
         .clk     (clk),
         .rst_n   (rst_n),
         .load    (bus.load),
         .d       (bus.load_val[DIGIT_W*i +: DIGIT_W]),
         .inc     (w_inc[i]),
         .dec     (w_dec[i]),
         .q       (w_q[DIGIT_W*i +: DIGIT_W]),
         .at_max  (w_at_max[i]),
         .at_zero (w_at_zero[i])
      );
   end
   // Digit k steps when every lower digit sits at its limit; the full chain is tc.
   always_comb begin
      logic all_max;
      logic all_zero;
      all_max  = 1'b1;
      all_zero = 1'b1;
      w_inc    = '0;
      w_dec    = '0;
      for (int k = 0; k < DIGITS; k++) begin
         w_inc[k] = bus.en & bus.up & all_max;
         w_dec[k] = bus.en & ~bus.up & all_zero;
         all_max  = all_max & w_at_max[k];
         all_zero = all_zero & w_at_zero[k];
      end
      w_tc = bus.en & (bus.up ? all_max : all_zero);
   end
   always_ff @(posedge clk) begin
      if (!rst_n) r_wrap <= 1'b0;
      else        r_wrap <= w_tc & ~bus.load;
   end
   assign bus.q    = w_q;
   assign bus.tc   = w_tc;
   assign bus.wrap = r_wrap;
endmodule

// File: tb/tb_bcd_counter_n.sv
// tb_bcd_counter_n: directed and random checks of two counter instances against an integer-value model.
module tb_bcd_counter_n;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bcd_counter_n_if #(.DIGITS(3)) a_if ();
   bcd_counter_n_if #(.DIGITS(2)) b_if ();
   bcd_counter_n #(.DIGITS(3), .MOD(10)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
   bcd_counter_n #(.DIGITS(2), .MOD(6))  dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));

   int tests = 0;
   int fails = 0;
   int ma = 0;
   int mb = 0;
   bit mwa = 0;
   bit mwb = 0;
   bit chk_on = 0;

   function automatic int pw(input int m, input int d);
      int r = 1;
      for (int k = 0; k < d; k++) r = r * m;
      return r;
   endfunction

   function automatic logic [15:0] pack(input int v, input int m, input int d);
      logic [15:0] r = '0;
      for (int k = 0; k < d; k++) r[4*k +: 4] = 4'((v / pw(m, k)) % m);
      return r;
   endfunction

   function automatic int unpack(input logic [15:0] lv, input int m, input int d);
      int r = 0;
      for (int k = 0; k < d; k++) r += ((int'(lv[4*k +: 4]) >= m) ? 0 : int'(lv[4*k +: 4])) * pw(m, k);
      return r;
   endfunction

   task automatic check(input string n, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
      end
   endtask

   // Model: the count is one integer in 0..MOD**DIGITS-1; digits are derived from it.
   always @(posedge clk) begin
      if (!rst_n) begin
         ma = 0; mwa = 0; mb = 0; mwb = 0;
      end else begin
         if (a_if.load) begin
            ma = unpack(16'(a_if.load_val), 10, 3); mwa = 0;
         end else if (a_if.en) begin
            mwa = a_if.up ? (ma == 999) : (ma == 0);
            ma  = a_if.up ? (ma + 1) % 1000 : (ma + 999) % 1000;
         end else mwa = 0;
         if (b_if.load) begin
            mb = unpack(16'(b_if.load_val), 6, 2); mwb = 0;
         end else if (b_if.en) begin
            mwb = b_if.up ? (mb == 35) : (mb == 0);
            mb  = b_if.up ? (mb + 1) % 36 : (mb + 35) % 36;
         end else mwb = 0;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         check("a_q", 16'(a_if.q), pack(ma, 10, 3));
         check("a_wrap", 16'(a_if.wrap), 16'(mwa));
         check("a_tc", 16'(a_if.tc), 16'(a_if.en && (a_if.up ? ma == 999 : ma == 0)));
         check("b_q", 16'(b_if.q), pack(mb, 6, 2));
         check("b_wrap", 16'(b_if.wrap), 16'(mwb));
         check("b_tc", 16'(b_if.tc), 16'(b_if.en && (b_if.up ? mb == 35 : mb == 0)));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic lda(input logic [11:0] v);
      a_if.load = 1'b1; a_if.load_val = v;
      tick(1);
      a_if.load = 1'b0;
   endtask

   initial begin
      int wraps;
      a_if.en = 1'b1; a_if.up = 1'b1; a_if.load = 1'b1; a_if.load_val = 12'h555;
      b_if.en = 1'b0; b_if.up = 1'b1; b_if.load = 1'b0; b_if.load_val = 8'h00;
      rst_n = 1'b0;
      tick(2);
      check("reset_q", 16'(a_if.q), 16'h000);
      check("reset_wrap", 16'(a_if.wrap), 16'h0);
      chk_on = 1;
      rst_n = 1'b1; a_if.load = 1'b0;
      tick(12);
      check("count12", 16'(a_if.q), 16'h012);
      lda(12'h998);
      tick(1);
      check("up_999", 16'(a_if.q), 16'h999);
      check("up_tc", 16'(a_if.tc), 16'h1);
      tick(1);
      check("up_wrap_q", 16'(a_if.q), 16'h000);
      check("up_wrap", 16'(a_if.wrap), 16'h1);
      tick(1);
      check("wrap_once", 16'(a_if.wrap), 16'h0);
      lda(12'h100);
      a_if.up = 1'b0;
      tick(1);
      check("borrow", 16'(a_if.q), 16'h099);
      lda(12'h000);
      tick(1);
      check("down_wrap_q", 16'(a_if.q), 16'h999);
      check("down_wrap", 16'(a_if.wrap), 16'h1);
      a_if.en = 1'b0;
      lda(12'h0C5);
      check("clamp", 16'(a_if.q), 16'h005);
      a_if.en = 1'b1; a_if.up = 1'b1;
      lda(12'h123);
      check("load_wins", 16'(a_if.q), 16'h123);
      lda(12'h999);
      a_if.en = 1'b0;
      #1 check("tc_en0", 16'(a_if.tc), 16'h0);
      tick(1);
      check("hold", 16'(a_if.q), 16'h999);
      rst_n = 1'b0; a_if.load = 1'b1; a_if.load_val = 12'h456;
      tick(1);
      check("rst_over_load", 16'(a_if.q), 16'h000);
      rst_n = 1'b1; a_if.load = 1'b0;
      b_if.en = 1'b1; b_if.up = 1'b1;
      wraps = 0;
      for (int e = 1; e <= 36; e++) begin
         tick(1);
         if (b_if.wrap) wraps++;
         if (e == 36) check("b_wrap36", 16'(b_if.wrap), 16'h1);
      end
      check("b_q36", 16'(b_if.q), 16'h00);
      check("b_wraps", 16'(wraps), 16'h1);
      for (int c = 0; c < 600; c++) begin
         rst_n = ($urandom_range(0, 59) != 0);
         a_if.en = ($urandom_range(0, 3) != 0);
         a_if.up = 1'($urandom);
         a_if.load = ($urandom_range(0, 15) == 0);
         a_if.load_val = ($urandom_range(0, 3) == 0) ? 12'h999 : 12'($urandom);
         b_if.en = ($urandom_range(0, 3) != 0);
         b_if.up = 1'($urandom);
         b_if.load = ($urandom_range(0, 15) == 0);
         b_if.load_val = ($urandom_range(0, 3) == 0) ? 8'h55 : 8'($urandom);
         tick(1);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
